alu_cmd_seq: RTL and testbench

Command sequencer that drives the 2-bit-controlled OR/AND ALU from the opposite side of its interface. It accepts operation commands over a valid/ready handshake and generates the ALU control code and operands, and it captures the ALU result. It also maintains an accumulator for chained operations and returns each result over a valid/ready response channel. It sits between the instruction/control path and the ALU, replacing hand-wired control of the ALU's operation-select input.

---
 rtl/alu_cmd_seq.sv | 114 +++++++++++
 tb/tb_alu_cmd_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 2-bit OR/AND ALU: accepts commands, drives ALU control and
// operands for one cycle, captures the result and returns it over a valid/ready channel.
module alu_cmd_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic [2:0]       Cmd_op,
  input  logic [WIDTH-1:0] Cmd_A,
  input  logic [WIDTH-1:0] Cmd_B,
  output logic [1:0]       Upr_ALU,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Out_ALU,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [WIDTH-1:0] Res_data,
  output logic [WIDTH-1:0] Acc,
  output logic             Busy,
  output logic [CNT_W-1:0] Op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ops 4..6 write the ALU result back into the accumulator; ACC_READ only observes it.
  assign acc_wr = (op_q == 3'd4) || (op_q == 3'd5) || (op_q == 3'd6);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (Cmd_valid) begin
          op_d    = Cmd_op;
          a_d     = Cmd_A;
          b_d     = Cmd_B;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d = Out_ALU;
        if (acc_wr) acc_d = Out_ALU;
        state_d = StResp;
      end
      StResp: begin
        if (Res_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Upr_ALU = 2'd0;
    A       = '0;
    B       = '0;
    if (state_q == StExec) begin
      unique case (op_q)
        3'd4: begin Upr_ALU = 2'd2; A = acc_q; B = b_q; end
        3'd5: begin Upr_ALU = 2'd3; A = acc_q; B = b_q; end
        3'd6: begin Upr_ALU = 2'd0; A = acc_q; B = '0;  end
        3'd7: begin Upr_ALU = 2'd2; A = acc_q; B = '0;  end
        default: begin Upr_ALU = op_q[1:0]; A = a_q; B = b_q; end
      endcase
    end
  end

  assign Cmd_ready = (state_q == StIdle);
  assign Res_valid = (state_q == StResp);
  assign Busy      = (state_q != StIdle);
  assign Res_data  = res_q;
  assign Acc       = acc_q;
  assign Op_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural OR/AND ALU closing the loop.
module tb_alu_cmd_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       upr_alu;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] out_alu;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  // Reference ALU: constant op gives exactly 1.
  always_comb begin
    out_alu = '0;
    case (upr_alu)
      2'd0: out_alu = '0;
      2'd1: out_alu = 32'd1;
      2'd2: out_alu = alu_a | alu_b;
      2'd3: out_alu = alu_a & alu_b;
      default: out_alu = '0;
    endcase
  end

  alu_cmd_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .Cmd_valid(cmd_valid),
    .Cmd_ready(cmd_ready),
    .Cmd_op   (cmd_op),
    .Cmd_A    (cmd_a),
    .Cmd_B    (cmd_b),
    .Upr_ALU  (upr_alu),
    .A        (alu_a),
    .B        (alu_b),
    .Out_ALU  (out_alu),
    .Res_valid(res_valid),
    .Res_ready(res_ready),
    .Res_data (res_data),
    .Acc      (acc),
    .Busy     (busy),
    .Op_count (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  // Full accept / EXEC / RESP sequence with the response taken immediately.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] e_upr, input logic [31:0] e_a,
                         input logic [31:0] e_b, input logic [31:0] e_res,
                         input logic [31:0] e_acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    step();
    // Scramble the inputs: the registered copy must be used.
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_a     = ~a;
    cmd_b     = ~b;
    check({tag, " exec upr"}, 32'(upr_alu), 32'(e_upr));
    check({tag, " exec A"}, alu_a, e_a);
    check({tag, " exec B"}, alu_b, e_b);
    check({tag, " exec ready"}, 32'(cmd_ready), 32'd0);
    step();
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " res_data"}, res_data, e_res);
    check({tag, " acc"}, acc, e_acc);
    check({tag, " resp upr"}, 32'(upr_alu), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + CNT_W'(1);
    check({tag, " done valid"}, 32'(res_valid), 32'd0);
    check({tag, " count"}, 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [31:0] held;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    exp_cnt   = '0;
    step();
    step();
    rst = 1'b0;

    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst acc", acc, 32'd0);
    check("rst count", 32'(op_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst upr", 32'(upr_alu), 32'd0);
    check("rst A", alu_a, 32'd0);
    check("rst B", alu_b, 32'd0);

    // Res_ready while idle does nothing.
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("idle rready count", 32'(op_count), 32'd0);
    check("idle rready valid", 32'(res_valid), 32'd0);

    // Reset during EXEC of ACC_OR 0xFFFF_FFFF discards the command.
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_b     = 32'hFFFF_FFFF;
    step();
    cmd_valid = 1'b0;
    check("midrst exec busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst res_valid", 32'(res_valid), 32'd0);
    check("midrst acc", acc, 32'd0);
    check("midrst count", 32'(op_count), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    check("midrst later valid", 32'(res_valid), 32'd0);
    check("midrst later acc", acc, 32'd0);

    run_cmd("or", 3'd2, 32'h0000_00F0, 32'h0000_000F, 2'd2, 32'h0000_00F0, 32'h0000_000F,
            32'h0000_00FF, 32'h0);

    do_reset();
    run_cmd("zero", 3'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'd0, 32'hFFFF_0000, 32'h0F0F_0F0F,
            32'h0, 32'h0);
    run_cmd("one", 3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'd1, 32'hFFFF_0000, 32'h0F0F_0F0F,
            32'h1, 32'h0);
    run_cmd("and", 3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F,
            32'h0F0F_0000, 32'h0);
    check("direct count3", 32'(op_count), 32'd3);

    run_cmd("accor1", 3'd4, 32'hDEAD_BEEF, 32'h1234_0000, 2'd2, 32'h0, 32'h1234_0000,
            32'h1234_0000, 32'h1234_0000);
    run_cmd("accor2", 3'd4, 32'hDEAD_BEEF, 32'h0000_5678, 2'd2, 32'h1234_0000, 32'h0000_5678,
            32'h1234_5678, 32'h1234_5678);
    run_cmd("accand", 3'd5, 32'hDEAD_BEEF, 32'hFF00_FF00, 2'd3, 32'h1234_5678, 32'hFF00_FF00,
            32'h1200_5600, 32'h1200_5600);
    run_cmd("accread", 3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'd2, 32'h1200_5600, 32'h0,
            32'h1200_5600, 32'h1200_5600);
    run_cmd("accclr", 3'd6, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'd0, 32'h1200_5600, 32'h0,
            32'h0, 32'h0);

    // Backpressure: response held 10 cycles while a second command waits.
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_a     = 32'hA000_0000;
    cmd_b     = 32'h0000_000A;
    step();
    cmd_op = 3'd3;
    cmd_a  = 32'hFF00_0000;
    cmd_b  = 32'h0F00_0000;
    step();
    held = 32'hA000_000A;
    for (int i = 0; i < 10; i++) begin
      check("bp valid", 32'(res_valid), 32'd1);
      check("bp data", res_data, held);
      check("bp cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp count", 32'(op_count), 32'(exp_cnt));
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + CNT_W'(1);
    check("bp hs count", 32'(op_count), 32'(exp_cnt));
    check("bp hs idle ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("bp second exec upr", 32'(upr_alu), 32'd3);
    check("bp second exec A", alu_a, 32'hFF00_0000);
    step();
    check("bp second res", res_data, 32'h0F00_0000);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + CNT_W'(1);
    check("bp second count", 32'(op_count), 32'(exp_cnt));

    // Counter wrap with CNT_W=4: 1 + 15 commands return the count to 0.
    do_reset();
    run_cmd("wrap acc", 3'd4, 32'h0, 32'hA5A5_A5A5, 2'd2, 32'h0, 32'hA5A5_A5A5,
            32'hA5A5_A5A5, 32'hA5A5_A5A5);
    for (int i = 0; i < 15; i++) begin
      run_cmd("wrap", 3'd2, 32'(i), 32'h0000_0100, 2'd2, 32'(i), 32'h0000_0100,
              32'(i) | 32'h0000_0100, 32'hA5A5_A5A5);
    end
    check("wrap count zero", 32'(op_count), 32'd0);
    check("wrap acc kept", acc, 32'hA5A5_A5A5);
    check("wrap idle", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
